// File: rtl/wasm_frame_alloc_if.sv
// -----------------------------------------------------------------------------
// wasm_frame_pkg / wasm_frame_alloc_if
//
// Purpose:
//   Shared types and the bundled bus for the WebAssembly call-frame allocator.
//   The package holds the value-type encoding and the operand-stack entry
//   layout. The interface groups every non-clock/reset signal of the allocator.
//
// Port summary (interface signals):
//   call_valid/call_ready, call_param_count, call_local_count : frame entry
//   ret_valid/ret_ready                                       : frame exit
//   type_idx -> type_in                                       : declared-type lookup
//   pop_req/pop_ack/pop_data                                  : operand-stack pops
//   wr_en, wr_base_idx, wr_local_idx, wr_data                 : locals-store writes
//   frame_base, frame_depth, done, err, type_err              : status
//
// Modports:
//   master : the environment (caller, operand stack, type table)
//   slave  : the allocator
// -----------------------------------------------------------------------------
package wasm_frame_pkg;

  localparam int LOCAL_COUNT      = 16;
  localparam int CALL_STACK_DEPTH = 8;

  typedef enum logic [1:0] {
    I32 = 2'd0,
    I64 = 2'd1,
    F32 = 2'd2,
    F64 = 2'd3
  } valtype_t;

  typedef struct packed {
    valtype_t    vtype;
    logic [63:0] value;
  } stack_entry_t;

endpackage

interface wasm_frame_alloc_if;
  import wasm_frame_pkg::*;

  logic         call_valid;
  logic         call_ready;
  logic [7:0]   call_param_count;
  logic [7:0]   call_local_count;

  logic [4:0]   type_idx;
  valtype_t     type_in;

  logic         pop_req;
  logic         pop_ack;
  stack_entry_t pop_data;

  logic         wr_en;
  logic [15:0]  wr_base_idx;
  logic [7:0]   wr_local_idx;
  stack_entry_t wr_data;

  logic         ret_valid;
  logic         ret_ready;
  logic [15:0]  frame_base;
  logic [7:0]   frame_depth;
  logic         done;
  logic         err;
  logic         type_err;

  modport master (
    output call_valid, call_param_count, call_local_count,
    output type_in,
    output pop_ack, pop_data,
    output ret_valid,
    input  call_ready, type_idx, pop_req,
    input  wr_en, wr_base_idx, wr_local_idx, wr_data,
    input  ret_ready, frame_base, frame_depth, done, err, type_err
  );

  modport slave (
    input  call_valid, call_param_count, call_local_count,
    input  type_in,
    input  pop_ack, pop_data,
    input  ret_valid,
    output call_ready, type_idx, pop_req,
    output wr_en, wr_base_idx, wr_local_idx, wr_data,
    output ret_ready, frame_base, frame_depth, done, err, type_err
  );

endinterface

// File: rtl/wasm_frame_alloc.sv
// -----------------------------------------------------------------------------
// wasm_frame_alloc
//
// Purpose:
//   Allocates a call frame in a flat locals store on function entry. Parameters
//   are popped from the operand stack (last parameter first) and written into
//   the new frame; the remaining locals are zero-filled with their declared
//   type. On return the previous frame is restored from an internal base stack.
//
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : wasm_frame_alloc_if.slave (call/ret handshakes, type lookup,
//          operand-stack pops, locals-store write port, status)
//
// Parameters:
//   MAX_LOCALS : total local slots in the locals store
//   MAX_DEPTH  : maximum nested frames
//   MAX_FRAME  : maximum locals (params included) per frame
//
// Configuration:
//   WASM_FRAME_TYPECHECK_EN : when defined, each popped parameter is compared
//   against its declared type and type_err pulses on a mismatch. When
//   undefined, type_err is tied low.
// -----------------------------------------------------------------------------
module wasm_frame_alloc
  import wasm_frame_pkg::*;
#(
  parameter int MAX_LOCALS = LOCAL_COUNT * CALL_STACK_DEPTH,
  parameter int MAX_DEPTH  = CALL_STACK_DEPTH,
  parameter int MAX_FRAME  = 32
) (
  input logic               clk,
  input logic               rst,
  wasm_frame_alloc_if.slave bus
);

  localparam int          SW           = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam logic [16:0] MAX_LOCALS_W = 17'(MAX_LOCALS);
  localparam logic [7:0]  MAX_DEPTH_W  = 8'(MAX_DEPTH);
  localparam logic [7:0]  MAX_FRAME_W  = 8'(MAX_FRAME);

  typedef enum logic [1:0] {
    IDLE,
    POP_PARAM,
    ZERO_FILL,
    FINISH
  } state_t;

  state_t       state_q, state_d;
  logic [7:0]   idx_q, idx_d;
  logic [7:0]   param_cnt_q, param_cnt_d;
  logic [7:0]   local_cnt_q, local_cnt_d;
  logic [15:0]  frame_base_q, frame_base_d;
  logic [15:0]  free_base_q, free_base_d;
  logic [7:0]   depth_q, depth_d;
  logic [15:0]  base_stack_q [MAX_DEPTH];
  logic [15:0]  base_stack_d [MAX_DEPTH];
  logic         err_q, err_d;

  logic         call_ready_c;
  logic         ret_ready_c;
  logic         pop_req_c;
  logic         wr_en_c;
  logic [15:0]  wr_base_c;
  logic [7:0]   wr_idx_c;
  stack_entry_t wr_data_c;
  logic [4:0]   type_idx_c;
  logic         done_c;

  logic [16:0]  call_sum;
  logic         call_bad;
  logic [SW-1:0] push_slot;
  logic [SW-1:0] pop_slot;

  // Widened sum so a frame near the top of the store cannot wrap past the limit.
  assign call_sum = {1'b0, free_base_q} + {9'b0, bus.call_local_count};

  assign call_bad = (call_sum > MAX_LOCALS_W)
                 || (depth_q == MAX_DEPTH_W)
                 || (bus.call_local_count > MAX_FRAME_W)
                 || (bus.call_param_count > bus.call_local_count);

  assign push_slot = depth_q[SW-1:0];
  assign pop_slot  = SW'(depth_q - 8'd1);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    param_cnt_d  = param_cnt_q;
    local_cnt_d  = local_cnt_q;
    frame_base_d = frame_base_q;
    free_base_d  = free_base_q;
    depth_d      = depth_q;
    base_stack_d = base_stack_q;
    err_d        = 1'b0;

    call_ready_c = (state_q == IDLE) && !bus.ret_valid;
    ret_ready_c  = (state_q == IDLE);
    pop_req_c    = 1'b0;
    wr_en_c      = 1'b0;
    wr_base_c    = 16'd0;
    wr_idx_c     = 8'd0;
    wr_data_c    = '0;
    type_idx_c   = 5'd0;
    done_c       = 1'b0;

    case (state_q)
      IDLE: begin
        // A return wins over a call presented in the same cycle.
        if (bus.ret_valid) begin
          if (depth_q == 8'd0) begin
            err_d = 1'b1;
          end else begin
            free_base_d  = frame_base_q;
            frame_base_d = base_stack_q[pop_slot];
            depth_d      = depth_q - 8'd1;
          end
        end else if (bus.call_valid) begin
          if (call_bad) begin
            err_d = 1'b1;
          end else begin
            base_stack_d[push_slot] = frame_base_q;
            frame_base_d = free_base_q;
            free_base_d  = call_sum[15:0];
            depth_d      = depth_q + 8'd1;
            param_cnt_d  = bus.call_param_count;
            local_cnt_d  = bus.call_local_count;
            // Parameters come off the stack last-first, so start at the top index.
            if (bus.call_param_count != 8'd0) begin
              idx_d   = bus.call_param_count - 8'd1;
              state_d = POP_PARAM;
            end else if (bus.call_local_count != 8'd0) begin
              idx_d   = 8'd0;
              state_d = ZERO_FILL;
            end else begin
              state_d = FINISH;
            end
          end
        end
      end

      POP_PARAM: begin
        pop_req_c  = 1'b1;
        type_idx_c = idx_q[4:0];
        if (bus.pop_ack) begin
          wr_en_c   = 1'b1;
          wr_base_c = frame_base_q;
          wr_idx_c  = idx_q;
          wr_data_c = bus.pop_data;
          if (idx_q == 8'd0) begin
            if (local_cnt_q > param_cnt_q) begin
              idx_d   = param_cnt_q;
              state_d = ZERO_FILL;
            end else begin
              state_d = FINISH;
            end
          end else begin
            idx_d = idx_q - 8'd1;
          end
        end
      end

      ZERO_FILL: begin
        type_idx_c      = idx_q[4:0];
        wr_en_c         = 1'b1;
        wr_base_c       = frame_base_q;
        wr_idx_c        = idx_q;
        wr_data_c.vtype = bus.type_in;
        wr_data_c.value = 64'd0;
        if (idx_q == local_cnt_q - 8'd1) begin
          state_d = FINISH;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end

      FINISH: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // While reset is held the outputs already show their reset values, so a
    // setup interrupted by reset issues no further pops or writes.
    if (rst) begin
      call_ready_c = 1'b0;
      ret_ready_c  = 1'b0;
      pop_req_c    = 1'b0;
      wr_en_c      = 1'b0;
      wr_base_c    = 16'd0;
      wr_idx_c     = 8'd0;
      wr_data_c    = '0;
      type_idx_c   = 5'd0;
      done_c       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= 8'd0;
      param_cnt_q  <= 8'd0;
      local_cnt_q  <= 8'd0;
      frame_base_q <= 16'd0;
      free_base_q  <= 16'd0;
      depth_q      <= 8'd0;
      err_q        <= 1'b0;
      for (int i = 0; i < MAX_DEPTH; i++) begin
        base_stack_q[i] <= 16'd0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      param_cnt_q  <= param_cnt_d;
      local_cnt_q  <= local_cnt_d;
      frame_base_q <= frame_base_d;
      free_base_q  <= free_base_d;
      depth_q      <= depth_d;
      err_q        <= err_d;
      base_stack_q <= base_stack_d;
    end
  end

  assign bus.call_ready   = call_ready_c;
  assign bus.ret_ready    = ret_ready_c;
  assign bus.pop_req      = pop_req_c;
  assign bus.wr_en        = wr_en_c;
  assign bus.wr_base_idx  = wr_base_c;
  assign bus.wr_local_idx = wr_idx_c;
  assign bus.wr_data      = wr_data_c;
  assign bus.type_idx     = type_idx_c;
  assign bus.done         = done_c;
  assign bus.err          = err_q && !rst;
  assign bus.frame_base   = frame_base_q;
  assign bus.frame_depth  = depth_q;

`ifdef WASM_FRAME_TYPECHECK_EN
  logic type_err_q, type_err_d;

  // type_in reflects the declared type of idx_q here, since type_idx follows idx.
  always_comb begin
    type_err_d = (state_q == POP_PARAM) && bus.pop_ack
              && (bus.pop_data.vtype != bus.type_in);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      type_err_q <= 1'b0;
    end else begin
      type_err_q <= type_err_d;
    end
  end

  assign bus.type_err = type_err_q && !rst;
`else
  assign bus.type_err = 1'b0;
`endif

endmodule

// File: tb/tb_wasm_frame_alloc.sv
// -----------------------------------------------------------------------------
// tb_wasm_frame_alloc
//
// Scoreboard bench for wasm_frame_alloc (MAX_LOCALS=8, MAX_DEPTH=4).
// The stimulus side predicts frame bookkeeping with a simple reference model
// (base stack as a queue, integer free pointer) and queues the writes and
// pulses it expects; a negedge monitor pops and compares whenever the DUT
// presents a write, done, err or type_err. A responder process plays the
// operand stack, optionally stalling pop_ack.
// -----------------------------------------------------------------------------
module tb_wasm_frame_alloc;
  import wasm_frame_pkg::*;

  localparam int M_LOCALS = 8;
  localparam int M_DEPTH  = 4;
  localparam int M_FRAME  = 32;

  typedef struct {
    logic [15:0] base;
    logic [7:0]  idx;
    valtype_t    vtype;
    logic [63:0] value;
  } wr_exp_t;

  logic clk;
  logic rst;

  wasm_frame_alloc_if bus ();

  wasm_frame_alloc #(
    .MAX_LOCALS (M_LOCALS),
    .MAX_DEPTH  (M_DEPTH),
    .MAX_FRAME  (M_FRAME)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Declared-type table the DUT looks up combinationally.
  valtype_t decl_types [32];
  assign bus.type_in = decl_types[bus.type_idx];

  int           n_checks = 0;
  int           n_fail   = 0;
  wr_exp_t      wr_q [$];
  int           exp_done     = 0;
  int           exp_err      = 0;
  int           exp_type_err = 0;
  stack_entry_t op_q [$];
  stack_entry_t ops_buf [32];
  bit           rand_stall  = 0;
  int           hold_cycles = 0;

  int           m_base  = 0;
  int           m_free  = 0;
  int           m_depth = 0;
  int           m_stack [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Operand-stack responder: acts just after each rising edge so the
  // combinational write port is stable at the sampling negedge.
  initial begin
    bus.pop_ack  = 1'b0;
    bus.pop_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.pop_req && hold_cycles > 0) begin
        hold_cycles--;
        bus.pop_ack = 1'b0;
      end else if (bus.pop_req && op_q.size() > 0 &&
                   (!rand_stall || $urandom_range(0, 2) != 0)) begin
        bus.pop_ack  = 1'b1;
        bus.pop_data = op_q.pop_front();
      end else begin
        bus.pop_ack = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  wr_exp_t mon_e;
  always @(negedge clk) begin
    if (bus.wr_en) begin
      if (wr_q.size() == 0) begin
        checkOutput("write_unexpected", {63'd0, bus.wr_en}, 64'd0);
      end else begin
        mon_e = wr_q.pop_front();
        checkOutput("wr_base_idx", {48'd0, bus.wr_base_idx}, {48'd0, mon_e.base});
        checkOutput("wr_local_idx", {56'd0, bus.wr_local_idx}, {56'd0, mon_e.idx});
        checkOutput("wr_vtype", {62'd0, bus.wr_data.vtype}, {62'd0, mon_e.vtype});
        checkOutput("wr_value", bus.wr_data.value, mon_e.value);
      end
    end
    if (bus.done) begin
      if (exp_done > 0) exp_done--;
      else checkOutput("done_unexpected", {63'd0, bus.done}, 64'd0);
    end
    if (bus.err) begin
      if (exp_err > 0) exp_err--;
      else checkOutput("err_unexpected", {63'd0, bus.err}, 64'd0);
    end
    if (bus.type_err) begin
      if (exp_type_err > 0) exp_type_err--;
      else checkOutput("type_err_unexpected", {63'd0, bus.type_err}, 64'd0);
    end
  end

  // kind: 0 = call, 1 = return, 2 = call and return together.
  task automatic applyStimulus(input int kind, input int p, input int l);
    bit bad;
    bit check_lat;
    int done_cycle;
    bit finished;
    bad        = 1'b0;
    check_lat  = (!rand_stall && hold_cycles == 0 && kind == 0);
    done_cycle = -1;
    finished   = 1'b0;
    @(negedge clk);
    if (kind == 0) begin
      bad = (m_free + l > M_LOCALS) || (m_depth == M_DEPTH) || (l > M_FRAME) || (p > l);
      if (bad) begin
        exp_err++;
      end else begin
        for (int k = 0; k < p; k++) begin
          op_q.push_back(ops_buf[k]);
          wr_q.push_back('{base: 16'(m_free), idx: 8'(p - 1 - k),
                           vtype: ops_buf[k].vtype, value: ops_buf[k].value});
`ifdef WASM_FRAME_TYPECHECK_EN
          if (ops_buf[k].vtype != decl_types[p - 1 - k]) exp_type_err++;
`endif
        end
        for (int k = p; k < l; k++) begin
          wr_q.push_back('{base: 16'(m_free), idx: 8'(k),
                           vtype: decl_types[k], value: 64'd0});
        end
        exp_done++;
        m_stack.push_back(m_base);
        m_base = m_free;
        m_free = m_free + l;
        m_depth++;
      end
    end else begin
      if (m_depth == 0) begin
        bad = 1'b1;
        exp_err++;
      end else begin
        m_free = m_base;
        m_base = m_stack.pop_back();
        m_depth--;
      end
    end
    bus.call_valid       = (kind != 1);
    bus.ret_valid        = (kind != 0);
    bus.call_param_count = 8'(p);
    bus.call_local_count = 8'(l);
    #1;
    checkOutput("call_ready", {63'd0, bus.call_ready}, {63'd0, (kind == 0)});
    checkOutput("ret_ready", {63'd0, bus.ret_ready}, 64'd1);
    @(posedge clk);
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        bus.call_valid = 1'b0;
        bus.ret_valid  = 1'b0;
        checkOutput("err_pulse", {63'd0, bus.err}, {63'd0, bad});
      end
      if (bus.done) done_cycle = cyc + 2;
      if (bus.ret_ready) begin
        finished = 1'b1;
        break;
      end
    end
    checkOutput("op_complete", {63'd0, finished}, 64'd1);
    if (check_lat && !bad) begin
      checkOutput("setup_latency", 64'(done_cycle), 64'(l + 2));
    end
    checkOutput("frame_base", {48'd0, bus.frame_base}, 64'(m_base));
    checkOutput("frame_depth", {56'd0, bus.frame_depth}, 64'(m_depth));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst                  = 1'b1;
    bus.call_valid       = 1'b0;
    bus.ret_valid        = 1'b0;
    bus.call_param_count = 8'd0;
    bus.call_local_count = 8'd0;
    for (int i = 0; i < 32; i++) decl_types[i] = I32;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_wr_en", {63'd0, bus.wr_en}, 64'd0);
    checkOutput("rst_pop_req", {63'd0, bus.pop_req}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_call_ready", {63'd0, bus.call_ready}, 64'd1);
    checkOutput("rst_ret_ready", {63'd0, bus.ret_ready}, 64'd1);
    checkOutput("rst_frame_base", {48'd0, bus.frame_base}, 64'd0);
    checkOutput("rst_depth", {56'd0, bus.frame_depth}, 64'd0);
    checkOutput("rst_type_idx", {59'd0, bus.type_idx}, 64'd0);

    // Two params, four locals, back-to-back pops.
    decl_types[0] = I32; decl_types[1] = I64; decl_types[2] = F32; decl_types[3] = F64;
    ops_buf[0].vtype = I64; ops_buf[0].value = 64'h1111_2222_3333_4444;
    ops_buf[1].vtype = I32; ops_buf[1].value = 64'h0000_0000_dead_beef;
    applyStimulus(0, 2, 4);

    // Zero-param frame, then unwind past the bottom.
    applyStimulus(0, 0, 3);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);

    // Oversized frame, then call and return presented together.
    applyStimulus(0, 0, 9);
    applyStimulus(0, 0, 1);
    applyStimulus(2, 0, 1);

    // Operand stack withholds pop_ack for five cycles.
    ops_buf[0].vtype = I32; ops_buf[0].value = 64'h5;
    ops_buf[1].vtype = I32; ops_buf[1].value = 64'h6;
    decl_types[0] = I32; decl_types[1] = I32;
    hold_cycles = 5;
    fork
      applyStimulus(0, 2, 2);
      begin
        bit seen;
        seen = 1'b0;
        for (int w = 0; w < 20; w++) begin
          @(negedge clk);
          if (bus.pop_req) begin
            seen = 1'b1;
            break;
          end
        end
        checkOutput("stall_reached_pop", {63'd0, seen}, 64'd1);
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          checkOutput("stall_pop_req", {63'd0, bus.pop_req}, 64'd1);
          checkOutput("stall_wr_en", {63'd0, bus.wr_en}, 64'd0);
          checkOutput("stall_type_idx", {59'd0, bus.type_idx}, 64'd1);
        end
      end
    join
    applyStimulus(1, 0, 0);

    // Reset during zero-fill: only the first write may land.
    @(negedge clk);
    wr_q.push_back('{base: 16'(m_free), idx: 8'd0, vtype: decl_types[0], value: 64'd0});
    bus.call_valid       = 1'b1;
    bus.call_param_count = 8'd0;
    bus.call_local_count = 8'd6;
    @(posedge clk);
    @(negedge clk);
    bus.call_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_base = 0; m_free = 0; m_depth = 0;
    m_stack.delete();
    @(negedge clk);
    checkOutput("abort_call_ready", {63'd0, bus.call_ready}, 64'd1);
    checkOutput("abort_wr_en", {63'd0, bus.wr_en}, 64'd0);
    checkOutput("abort_pop_req", {63'd0, bus.pop_req}, 64'd0);
    checkOutput("abort_done", {63'd0, bus.done}, 64'd0);
    checkOutput("abort_frame_base", {48'd0, bus.frame_base}, 64'd0);
    checkOutput("abort_depth", {56'd0, bus.frame_depth}, 64'd0);
    repeat (4) @(negedge clk);

    // Parameter type differs from its declaration.
    decl_types[0] = I32;
    ops_buf[0].vtype = F32; ops_buf[0].value = 64'h3f80_0000;
    applyStimulus(0, 1, 1);
    applyStimulus(1, 0, 0);

    // Randomized mix of calls and returns with random pop stalls.
    rand_stall = 1'b1;
    for (int n = 0; n < 60; n++) begin
      int r, p, l;
      r = int'($urandom_range(0, 9));
      l = int'($urandom_range(0, 9));
      p = int'($urandom_range(0, 10));
      if (p > l && $urandom_range(0, 3) != 0) p = l;
      for (int i = 0; i < 32; i++) begin
        decl_types[i]    = valtype_t'($urandom_range(0, 3));
        ops_buf[i].vtype = valtype_t'($urandom_range(0, 3));
        ops_buf[i].value = {$urandom, $urandom};
      end
      if (r < 6) applyStimulus(0, p, l);
      else if (r < 9) applyStimulus(1, 0, 0);
      else applyStimulus(2, p, l);
    end

    repeat (5) @(negedge clk);
    checkOutput("writes_pending", 64'(wr_q.size()), 64'd0);
    checkOutput("done_pending", 64'(exp_done), 64'd0);
    checkOutput("err_pending", 64'(exp_err), 64'd0);
    checkOutput("type_err_pending", 64'(exp_type_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wasm_frame_alloc.md
WASM_FRAME_ALLOC -- requirements
Module: wasm_frame_alloc

Interface
REQ-001 SHALL have parameter MAX_LOCALS, default LOCAL_COUNT*CALL_STACK_DEPTH, meaning total local slots in the locals store.
REQ-002 SHALL have parameter MAX_DEPTH, default CALL_STACK_DEPTH, meaning maximum nested frames.
REQ-003 SHALL have parameter MAX_FRAME, default 32, meaning maximum locals (params included) per frame.
REQ-004 SHALL have one clock and a synchronous, active-high reset: port clk (in, 1, clock) and port rst (in, 1, reset), both sampled on the rising edge of clk.
REQ-005 SHALL have ports call_valid in 1 (frame-entry request); call_ready out 1 (accept); call_param_count in 8; call_local_count in 8 (total incl. params).
REQ-006 SHALL have ports type_idx out 5 (local index under lookup); type_in in valtype_t (declared type of type_idx, combinational).
REQ-007 SHALL have ports pop_req out 1 (operand-stack pop); pop_ack in 1 (pop_data valid this cycle); pop_data in stack_entry_t.
REQ-008 SHALL have ports wr_en out 1; wr_base_idx out 16; wr_local_idx out 8; wr_data out stack_entry_t (locals-store write port).
REQ-009 SHALL have ports ret_valid in 1 (frame exit); ret_ready out 1; frame_base out 16; frame_depth out 8; done out 1 (setup complete pulse); err out 1 (overflow/underflow pulse); type_err out 1 (param type mismatch pulse).

Function
REQ-010 SHALL implement states IDLE, POP_PARAM, ZERO_FILL, FINISH.
REQ-011 call_ready SHALL equal (state==IDLE && !ret_valid); ret_ready SHALL equal (state==IDLE); ret has priority over a simultaneous call.
REQ-012 On call accept, if free_base+call_local_count > MAX_LOCALS, frame_depth==MAX_DEPTH, call_local_count > MAX_FRAME, or call_param_count > call_local_count: err pulses 1 cycle next edge, no state change, stays IDLE.
REQ-013 Otherwise on accept: previous frame_base pushed to internal base stack, frame_base <= free_base, free_base <= free_base+call_local_count, frame_depth += 1, counts latched.
REQ-014 Next state after accept: POP_PARAM if params>0, else ZERO_FILL if locals>0, else FINISH.
REQ-015 POP_PARAM: pop_req=1; idx starts at params-1, decrements; on pop_ack, same cycle wr_en=1, wr_local_idx=idx, wr_data=pop_data, wr_base_idx=frame_base; no write without pop_ack; stalls indefinitely.
REQ-016 After pop_ack at idx 0: to ZERO_FILL if locals>params, else FINISH.
REQ-017 ZERO_FILL: one write per cycle, idx from params up to locals-1, wr_data.vtype=type_in with type_idx=idx, wr_data.value=0; after last idx to FINISH.
REQ-018 type_idx SHALL equal the current idx in POP_PARAM and ZERO_FILL, else 0.
REQ-019 FINISH: done=1 for exactly one cycle, then IDLE; total setup latency = 1 + params (zero pop stall) + (locals-params) + 1 cycles from accept.
REQ-020 Return accept with frame_depth==0: err pulses, no change; otherwise free_base <= frame_base, frame_base <= popped base, frame_depth -= 1, all next edge.
REQ-021 Sums SHALL be computed 17 bits wide before the MAX_LOCALS comparison; no wrap.
REQ-022 call_valid/ret_valid outside IDLE SHALL be ignored.

Reset
REQ-023 On rst: state IDLE, frame_base 0, free_base 0, frame_depth 0, base stack cleared; pop_req, wr_en, done, err, type_err 0; wr_* and type_idx 0; call_ready and ret_ready 1 the cycle after reset deasserts.
REQ-024 rst mid-setup SHALL abort without further writes or pops.

Configuration
REQ-025 With WASM_FRAME_TYPECHECK_EN defined, in POP_PARAM on pop_ack with pop_data.vtype != type_in, type_err SHALL pulse 1 cycle later; the write still occurs and setup continues.
REQ-026 Without WASM_FRAME_TYPECHECK_EN, type_err SHALL be tied 0 and no comparison logic exists.

Verification
REQ-027 Reset, call params=2 locals=4 types {I32,I64,F32,F64}, pop_ack every cycle with I64 then I32 -> writes idx1 then idx0 at base 0, then idx2 F32/0 and idx3 F64/0, done at cycle 6, frame_base 0, free_base 4, depth 1.
REQ-028 Second call params=0 locals=3 -> frame_base 4, 3 zero-fill writes, done; ret -> frame_base 0, depth 1; ret -> depth 0; third ret -> err pulse, state unchanged.
REQ-029 MAX_LOCALS=8, call locals=9 -> err pulse, no writes, depth 0; call_valid and ret_valid together in IDLE with depth 1 -> ret taken, call_ready 0.
REQ-030 POP_PARAM with pop_ack withheld 5 cycles -> pop_req held, wr_en 0, no progress; rst asserted during ZERO_FILL -> next cycle IDLE, outputs at reset values.
REQ-031 WASM_FRAME_TYPECHECK_EN defined, declared I32, pop_data.vtype F32 -> type_err pulse, write performed; undefined -> type_err stays 0.
